hacd_irq_coalesce: RTL and testbench

//  Parametrised N-channel interrupt coalescer for the HACD top level; drives the

---
 rtl/hacd_irq_coalesce.sv | 222 ++++++++++++++++++++++
 tb/tb_hacd_irq_coalesce.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hacd_irq_coalesce.sv
// hacd_irq_coalesce: per-channel event coalescer that raises sticky level IRQs
// on a count threshold or timeout; configured and acked over a 32-bit reg port.
module hacd_irq_coalesce #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int TMR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] evt_i,
    input  logic              reg_valid_i,
    input  logic              reg_write_i,
    input  logic [11:0]       reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    input  logic [3:0]        reg_wstrb_i,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_ready_o,
    output logic              reg_error_o,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FIRE
    } state_e;

    state_e             state_q [NUM_CH];
    state_e             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [TMR_W-1:0]   tmr_q   [NUM_CH];
    logic [TMR_W-1:0]   tmr_d   [NUM_CH];
    logic [CNT_W-1:0]   thr_q   [NUM_CH];
    logic [CNT_W-1:0]   thr_d   [NUM_CH];
    logic [TMR_W-1:0]   to_q    [NUM_CH];
    logic [TMR_W-1:0]   to_d    [NUM_CH];
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  ovf_q, ovf_d;

    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               req;
    logic               wr;
    logic [3:0]         ch_sel;
    logic [1:0]         off;
    logic               in_ch;
    logic               is_pend;
    logic               is_ack;
    logic [NUM_CH-1:0]  ch_hit;
    logic [NUM_CH-1:0]  ack;
    logic [NUM_CH-1:0]  hit;

    function automatic logic [31:0] wmerge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        end
        return res;
    endfunction

    // A new request is only sampled while no response is outstanding.
    assign req     = reg_valid_i && !ready_q;
    assign wr      = req && reg_write_i;
    assign ch_sel  = reg_addr_i[7:4];
    assign off     = reg_addr_i[3:2];
    assign in_ch   = (reg_addr_i[11:8] == 4'h0) && (reg_addr_i[1:0] == 2'b00)
                  && ({28'd0, ch_sel} < 32'(NUM_CH));
    assign is_pend = (reg_addr_i == 12'h100);
    assign is_ack  = (reg_addr_i == 12'h104);

    always_comb begin
        ch_hit = '0;
        ack    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = in_ch && (ch_sel == 4'(c));
            ack[c]    = wr && is_ack && reg_wstrb_i[c/8] && reg_wdata_i[c];
        end
    end

    always_comb begin
        irq_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            irq_o[c] = (state_q[c] == ST_FIRE);
        end
    end

    assign irq_any_o = |irq_o;

    always_comb begin
        ready_d = req;
        rdata_d = '0;
        err_d   = 1'b0;
        if (req) begin
            if (in_ch) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_hit[c] && !reg_write_i) begin
                        unique case (off)
                            2'd0: rdata_d = {31'd0, en_q[c]};
                            2'd1: rdata_d = 32'(thr_q[c]);
                            2'd2: rdata_d = 32'(to_q[c]);
                            default: begin
                                rdata_d[CNT_W-1:0] = cnt_q[c];
                                rdata_d[30]        = ovf_q[c];
                                rdata_d[31]        = (state_q[c] == ST_FIRE);
                            end
                        endcase
                    end
                end
            end else if (is_pend) begin
                if (!reg_write_i) rdata_d = 32'(irq_o);
            end else if (!is_ack) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        en_d  = en_q;
        ovf_d = ovf_q;
        hit   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            thr_d[c]   = thr_q[c];
            to_d[c]    = to_q[c];
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            tmr_d[c]   = tmr_q[c];
            hit[c] = (cnt_q[c] >= ((thr_q[c] == '0) ? CNT_W'(1) : thr_q[c]))
                  || ((to_q[c] != '0) && (tmr_q[c] >= to_q[c]));
            if (wr && ch_hit[c]) begin
                unique case (off)
                    2'd0: if (reg_wstrb_i[0]) en_d[c] = reg_wdata_i[0];
                    2'd1: thr_d[c] = CNT_W'(wmerge(32'(thr_q[c]), reg_wdata_i, reg_wstrb_i));
                    2'd2: to_d[c]  = TMR_W'(wmerge(32'(to_q[c]), reg_wdata_i, reg_wstrb_i));
                    default: ;
                endcase
            end
            // The new enable is what the event sees in the same cycle.
            if (!en_d[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = '0;
                tmr_d[c]   = '0;
                ovf_d[c]   = 1'b0;
            end else begin
                unique case (state_q[c])
                    ST_IDLE: begin
                        if (evt_i[c]) begin
                            state_d[c] = ST_ACCUM;
                            cnt_d[c]   = CNT_W'(1);
                            tmr_d[c]   = '0;
                        end
                    end
                    ST_ACCUM: begin
                        if (evt_i[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        if (tmr_q[c] != '1) tmr_d[c] = tmr_q[c] + TMR_W'(1);
                        if (hit[c]) state_d[c] = ST_FIRE;
                    end
                    ST_FIRE: begin
                        if (ack[c]) begin
                            ovf_d[c] = 1'b0;
                            tmr_d[c] = '0;
                            if (evt_i[c]) begin
                                state_d[c] = ST_ACCUM;
                                cnt_d[c]   = CNT_W'(1);
                            end else begin
                                state_d[c] = ST_IDLE;
                                cnt_d[c]   = '0;
                            end
                        end else if (evt_i[c]) begin
                            if (cnt_q[c] == '1) ovf_d[c] = 1'b1;
                            else cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end
                    end
                    default: state_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            en_q    <= '0;
            ovf_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                tmr_q[c]   <= '0;
                thr_q[c]   <= '0;
                to_q[c]    <= '0;
            end
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                tmr_q[c]   <= tmr_d[c];
                thr_q[c]   <= thr_d[c];
                to_q[c]    <= to_d[c];
            end
        end
    end

    assign reg_ready_o = ready_q;
    assign reg_error_o = err_q;
    assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_hacd_irq_coalesce.sv
// tb_hacd_irq_coalesce: directed stimulus against a cycle-level reference model
// of the coalescer; IRQs and register responses are compared every negedge.
module tb_hacd_irq_coalesce;

    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int TW  = 16;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam int unsigned TMAX = (1 << TW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NCH-1:0]    evt_i = '0;
    logic              reg_valid_i = 1'b0;
    logic              reg_write_i = 1'b0;
    logic [11:0]       reg_addr_i = '0;
    logic [31:0]       reg_wdata_i = '0;
    logic [3:0]        reg_wstrb_i = '0;
    logic [31:0]       reg_rdata_o;
    logic              reg_ready_o;
    logic              reg_error_o;
    logic [NCH-1:0]    irq_o;
    logic              irq_any_o;

    hacd_irq_coalesce #(
        .NUM_CH(NCH),
        .CNT_W (CW),
        .TMR_W (TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .evt_i      (evt_i),
        .reg_valid_i(reg_valid_i),
        .reg_write_i(reg_write_i),
        .reg_addr_i (reg_addr_i),
        .reg_wdata_i(reg_wdata_i),
        .reg_wstrb_i(reg_wstrb_i),
        .reg_rdata_o(reg_rdata_o),
        .reg_ready_o(reg_ready_o),
        .reg_error_o(reg_error_o),
        .irq_o      (irq_o),
        .irq_any_o  (irq_any_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = accumulating, 2 = firing.
    int          m_ph  [NCH];
    int unsigned m_cnt [NCH];
    int unsigned m_tmr [NCH];
    int unsigned m_thr [NCH];
    int unsigned m_to  [NCH];
    bit          m_en  [NCH];
    bit          m_ovf [NCH];
    bit          m_pend = 1'b0;
    bit          m_rd = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic int unsigned bmerge(input int unsigned old, input logic [31:0] w,
                                           input logic [3:0] s);
        int unsigned m;
        m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return (old & ~m) | (w & m);
    endfunction

    task automatic mread(input logic [11:0] a, output logic [31:0] d, output bit e);
        int ch;
        d  = '0;
        e  = 1'b0;
        ch = int'(a[7:4]);
        if (a < 12'h100) begin
            if (a[1:0] != 2'b00 || ch >= NCH) e = 1'b1;
            else begin
                case (a[3:2])
                    2'd0: d = m_en[ch] ? 32'd1 : 32'd0;
                    2'd1: d = m_thr[ch];
                    2'd2: d = m_to[ch];
                    default: d = (m_ph[ch] == 2 ? 32'h8000_0000 : 32'd0)
                              | (m_ovf[ch] ? 32'h4000_0000 : 32'd0) | m_cnt[ch];
                endcase
            end
        end else if (a == 12'h100) begin
            for (int c = 0; c < NCH; c++) if (m_ph[c] == 2) d = d | (32'd1 << c);
        end else if (a != 12'h104) begin
            e = 1'b1;
        end
    endtask

    task automatic mreset();
        for (int c = 0; c < NCH; c++) begin
            m_ph[c] = 0; m_cnt[c] = 0; m_tmr[c] = 0;
            m_thr[c] = 0; m_to[c] = 0; m_en[c] = 0; m_ovf[c] = 0;
        end
        m_pend = 0; m_rd = 0; m_err = 0; m_rdata = '0;
    endtask

    task automatic mstep();
        bit acc, wr, e, ev, fire;
        bit nen [NCH];
        bit ack [NCH];
        int unsigned nthr [NCH];
        int unsigned nto [NCH];
        logic [31:0] d;
        int ch;
        acc = reg_valid_i && !m_pend;
        wr  = acc && reg_write_i;
        d = '0;
        e = 1'b0;
        if (acc) mread(reg_addr_i, d, e);
        if (wr) d = '0;
        ch = int'(reg_addr_i[7:4]);
        for (int c = 0; c < NCH; c++) begin
            nen[c] = m_en[c]; nthr[c] = m_thr[c]; nto[c] = m_to[c]; ack[c] = 0;
        end
        if (wr && !e) begin
            if (reg_addr_i < 12'h100) begin
                case (reg_addr_i[3:2])
                    2'd0: if (reg_wstrb_i[0]) nen[ch] = reg_wdata_i[0];
                    2'd1: nthr[ch] = bmerge(m_thr[ch], reg_wdata_i, reg_wstrb_i) & CMAX;
                    2'd2: nto[ch] = bmerge(m_to[ch], reg_wdata_i, reg_wstrb_i) & TMAX;
                    default: ;
                endcase
            end else if (reg_addr_i == 12'h104) begin
                for (int c = 0; c < NCH; c++) ack[c] = reg_wstrb_i[c/8] && reg_wdata_i[c];
            end
        end
        for (int c = 0; c < NCH; c++) begin
            ev = evt_i[c];
            if (!nen[c]) begin
                m_ph[c] = 0; m_cnt[c] = 0; m_tmr[c] = 0; m_ovf[c] = 0;
            end else if (m_ph[c] == 0) begin
                if (ev) begin m_ph[c] = 1; m_cnt[c] = 1; m_tmr[c] = 0; end
            end else if (m_ph[c] == 1) begin
                fire = (m_cnt[c] >= ((m_thr[c] == 0) ? 1 : m_thr[c]))
                    || (m_to[c] != 0 && m_tmr[c] >= m_to[c]);
                if (ev && m_cnt[c] < CMAX) m_cnt[c]++;
                if (m_tmr[c] < TMAX) m_tmr[c]++;
                if (fire) m_ph[c] = 2;
            end else begin
                if (ack[c]) begin
                    m_ovf[c] = 0; m_tmr[c] = 0;
                    m_ph[c]  = ev ? 1 : 0;
                    m_cnt[c] = ev ? 1 : 0;
                end else if (ev) begin
                    if (m_cnt[c] == CMAX) m_ovf[c] = 1;
                    else m_cnt[c]++;
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = nen[c]; m_thr[c] = nthr[c]; m_to[c] = nto[c];
        end
        m_pend  = acc;
        m_rd    = acc && !reg_write_i;
        m_err   = e;
        m_rdata = d;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) mreset();
            else mstep();
        end
    end

    initial begin
        logic [NCH-1:0] ei;
        forever begin
            @(negedge clk_i);
            ei = '0;
            for (int c = 0; c < NCH; c++) if (m_ph[c] == 2) ei[c] = 1'b1;
            check("irq_o", 32'(irq_o), 32'(ei));
            check("irq_any_o", 32'(irq_any_o), 32'(|ei));
            check("reg_ready_o", 32'(reg_ready_o), 32'(m_pend));
            if (m_pend) begin
                check("reg_error_o", 32'(reg_error_o), 32'(m_err));
                if (m_rd) check("reg_rdata_o", reg_rdata_o, m_rdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk_i);
        reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = a;
        @(negedge clk_i);
        check("rd_ready", 32'(reg_ready_o), 32'd1);
        d = reg_rdata_o;
        e = reg_error_o;
        reg_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] w, input logic [3:0] s,
                      output logic e);
        @(negedge clk_i);
        reg_valid_i = 1'b1; reg_write_i = 1'b1;
        reg_addr_i = a; reg_wdata_i = w; reg_wstrb_i = s;
        @(negedge clk_i);
        check("wr_ready", 32'(reg_ready_o), 32'd1);
        e = reg_error_o;
        reg_valid_i = 1'b0; reg_write_i = 1'b0;
    endtask

    task automatic pulse(input int ch);
        @(negedge clk_i);
        evt_i[ch] = 1'b1;
        @(negedge clk_i);
        evt_i = '0;
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_ready", 32'(reg_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        rd(12'h00C, d, e); check("rst_status0", d, 32'd0);
        rd(12'h100, d, e); check("rst_pend", d, 32'd0);
        rd(12'h010, d, e); check("rst_ctrl1", d, 32'd0);

        // Threshold of 4 on channel 0
        wr(12'h000, 32'd1, 4'hF, e);
        wr(12'h004, 32'd4, 4'hF, e);
        wr(12'h008, 32'd0, 4'hF, e);
        for (int i = 0; i < 4; i++) pulse(0);
        check("t1_irq_pre", 32'(irq_o[0]), 32'd0);
        @(negedge clk_i);
        check("t1_irq_fire", 32'(irq_o[0]), 32'd1);
        rd(12'h00C, d, e); check("t1_status0", d, 32'h8000_0004);

        // Timeout of 10 on channel 1
        wr(12'h010, 32'd1, 4'hF, e);
        wr(12'h014, 32'd100, 4'hF, e);
        wr(12'h018, 32'd10, 4'hF, e);
        pulse(1);
        repeat (10) @(negedge clk_i);
        check("t2_irq_pre", 32'(irq_o[1]), 32'd0);
        @(negedge clk_i);
        check("t2_irq_fire", 32'(irq_o[1]), 32'd1);
        rd(12'h01C, d, e); check("t2_status1", d, 32'h8000_0001);
        rd(12'h100, d, e); check("t2_pend", d, 32'd3);

        // Saturation and overflow, then ACK
        @(negedge clk_i);
        evt_i[0] = 1'b1;
        repeat (70000) @(negedge clk_i);
        evt_i = '0;
        rd(12'h00C, d, e); check("t3_status_sat", d, 32'hC000_FFFF);
        wr(12'h104, 32'd1, 4'hF, e);
        check("t3_irq_acked", 32'(irq_o[0]), 32'd0);
        rd(12'h00C, d, e); check("t3_status_clr", d, 32'd0);

        // ACK coincident with an event re-arms immediately
        wr(12'h004, 32'd1, 4'hF, e);
        pulse(0);
        @(negedge clk_i);
        check("t4_irq_fire", 32'(irq_o[0]), 32'd1);
        @(negedge clk_i);
        evt_i[0] = 1'b1;
        reg_valid_i = 1'b1; reg_write_i = 1'b1;
        reg_addr_i = 12'h104; reg_wdata_i = 32'd1; reg_wstrb_i = 4'hF;
        @(negedge clk_i);
        evt_i = '0;
        reg_valid_i = 1'b0; reg_write_i = 1'b0;
        check("t4_irq_drop", 32'(irq_o[0]), 32'd0);
        @(negedge clk_i);
        check("t4_irq_refire", 32'(irq_o[0]), 32'd1);
        rd(12'h00C, d, e); check("t4_status0", d, 32'h8000_0001);

        // Error decode and byte strobes
        rd(12'h0F0, d, e);
        check("t5_err", 32'(e), 32'd1);
        check("t5_rdata", d, 32'd0);
        rd(12'h022, d, e); check("t5_misalign_err", 32'(e), 32'd1);
        wr(12'h200, 32'hFFFF_FFFF, 4'hF, e); check("t5_wr_err", 32'(e), 32'd1);
        wr(12'h00C, 32'hFFFF_FFFF, 4'hF, e); check("t5_ro_noerr", 32'(e), 32'd0);
        wr(12'h000, 32'd0, 4'h0, e);
        rd(12'h000, d, e); check("t5_ctrl_keep", d, 32'd1);
        wr(12'h014, 32'h0000_AB00, 4'b0010, e);
        rd(12'h014, d, e); check("t5_thr_strb", d, 32'h0000_AB64);

        // Asynchronous reset while both channels fire
        check("t6_both", 32'(irq_o), 32'd3);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_irq_async", 32'(irq_o), 32'd0);
        check("t6_any_async", 32'(irq_any_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        rd(12'h000, d, e); check("t6_ctrl0", d, 32'd0);
        pulse(0);
        pulse(1);
        @(negedge clk_i);
        check("t6_ignored", 32'(irq_o), 32'd0);
        rd(12'h00C, d, e); check("t6_status0", d, 32'd0);
        wr(12'h000, 32'd1, 4'hF, e);
        pulse(0);
        @(negedge clk_i);
        check("t6_thr0_as1", 32'(irq_o), 32'd1);
        rd(12'h00C, d, e); check("t6_status_refire", d, 32'h8000_0001);

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
